// File: rtl/mux157_share_arbiter.sv
// rtl/mux157_share_arbiter.sv - round-robin bounded-hold arbiter sharing one quad 2:1 mux
module mux157_share_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CW       = $clog2(MAX_HOLD) + 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_A,
    input  logic       REQ_B,
    output logic       GNT_A,
    output logic       GNT_B,
    output logic       E,
    output logic       S,
    input  logic [3:0] Y,
    output logic [3:0] DOUT,
    output logic       DVALID,
    output logic       DSRC
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          last_q, last_d;
    logic          gnt_a_q, gnt_b_q, e_q, s_q;
    logic          s_d;
    logic [3:0]    dout_q;
    logic          dvalid_q, dsrc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (REQ_A && REQ_B) state_d = last_q ? OWN_A : OWN_B;
                else if (REQ_A)     state_d = OWN_A;
                else if (REQ_B)     state_d = OWN_B;
            end
            OWN_A: begin
                if (!REQ_A)                            state_d = REQ_B ? OWN_B : IDLE;
                else if (REQ_B && hold_q == HOLD_LAST) state_d = OWN_B;
            end
            OWN_B: begin
                if (!REQ_B)                            state_d = REQ_A ? OWN_A : IDLE;
                else if (REQ_A && hold_q == HOLD_LAST) state_d = OWN_A;
            end
            default: state_d = IDLE;
        endcase
    end

    // The counter restarts on every grant entry, so a direct switch gives the new owner a full window.
    always_comb begin
        hold_d = hold_q;
        if (state_d == IDLE || state_d != state_q) hold_d = '0;
        else if (hold_q != HOLD_LAST)              hold_d = hold_q + CW'(1);
    end

    always_comb begin
        last_d = last_q;
        if (state_d == OWN_A && state_q != OWN_A) last_d = 1'b0;
        if (state_d == OWN_B && state_q != OWN_B) last_d = 1'b1;
    end

    always_comb begin
        s_d = s_q;
        if (state_d == OWN_A) s_d = 1'b0;
        if (state_d == OWN_B) s_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            last_q   <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            e_q      <= 1'b1;
            s_q      <= 1'b0;
            dout_q   <= 4'h0;
            dvalid_q <= 1'b0;
            dsrc_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
            gnt_a_q  <= (state_d == OWN_A);
            gnt_b_q  <= (state_d == OWN_B);
            e_q      <= (state_d == IDLE);
            s_q      <= s_d;
            // Capture what the mux drove during the cycle that is ending.
            if (!e_q) begin
                dout_q   <= Y;
                dsrc_q   <= s_q;
                dvalid_q <= 1'b1;
            end else begin
                dvalid_q <= 1'b0;
            end
        end
    end

    assign GNT_A  = gnt_a_q;
    assign GNT_B  = gnt_b_q;
    assign E      = e_q;
    assign S      = s_q;
    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;
    assign DSRC   = dsrc_q;

endmodule

// File: tb/tb_mux157_share_arbiter.sv
// tb/tb_mux157_share_arbiter.sv - directed self-checking bench for mux157_share_arbiter
module tb_mux157_share_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_A = 1'b0, REQ_B = 1'b0;
    logic       GNT_A, GNT_B, E, S, DVALID, DSRC;
    logic [3:0] Y, DOUT;

    logic       r1_a = 1'b0, r1_b = 1'b0;
    logic       g1_a, g1_b, e1, s1, dv1, ds1;
    logic [3:0] y1, do1;

    logic [3:0] a_dat = 4'hA;
    logic [3:0] b_dat = 4'h5;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    assign Y  = E  ? 4'h0 : (S  ? b_dat : a_dat);
    assign y1 = e1 ? 4'h0 : (s1 ? b_dat : a_dat);

    mux157_share_arbiter #(.MAX_HOLD(4)) dut (
        .CLK(CLK), .RST(RST), .REQ_A(REQ_A), .REQ_B(REQ_B),
        .GNT_A(GNT_A), .GNT_B(GNT_B), .E(E), .S(S), .Y(Y),
        .DOUT(DOUT), .DVALID(DVALID), .DSRC(DSRC)
    );

    mux157_share_arbiter #(.MAX_HOLD(1)) dut1 (
        .CLK(CLK), .RST(RST), .REQ_A(r1_a), .REQ_B(r1_b),
        .GNT_A(g1_a), .GNT_B(g1_b), .E(e1), .S(s1), .Y(y1),
        .DOUT(do1), .DVALID(dv1), .DSRC(ds1)
    );

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0; r1_a = 1'b0; r1_b = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1; REQ_A = 1'b1; REQ_B = 1'b1;
        repeat (2) @(negedge CLK);
        total++;
        if ({GNT_A, GNT_B, E, S} !== 4'b0010) begin
            bad++; $display("FAIL reset_ctrl got gnt_a,gnt_b,e,s=%b want 0010", {GNT_A, GNT_B, E, S});
        end
        total++;
        if ({DVALID, DOUT} !== 5'h00) begin
            bad++; $display("FAIL reset_data got dvalid=%b dout=%h want 0 0", DVALID, DOUT);
        end
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if ({GNT_A, GNT_B, E, S} !== 4'b1000) begin
            bad++; $display("FAIL first_tie got gnt_a,gnt_b,e,s=%b want 1000", {GNT_A, GNT_B, E, S});
        end
    endtask

    task automatic test_single();
        do_reset();
        REQ_A = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            total++;
            if ({GNT_A, GNT_B, E, S} !== 4'b1000) begin
                bad++; $display("FAIL single_gnt k=%0d got %b want 1000", k, {GNT_A, GNT_B, E, S});
            end
            if (k >= 2) begin
                total++;
                if ({DVALID, DSRC, DOUT} !== 6'b10_1010) begin
                    bad++; $display("FAIL single_data k=%0d got dv=%b src=%b dout=%h want 1 0 a", k, DVALID, DSRC, DOUT);
                end
            end else begin
                total++;
                if (DVALID !== 1'b0) begin
                    bad++; $display("FAIL single_first_dv got %b want 0", DVALID);
                end
            end
        end
        REQ_A = 1'b0;
        @(negedge CLK);
        total++;
        if ({GNT_A, GNT_B, E, S, DVALID, DOUT} !== 9'b0010_1_1010) begin
            bad++; $display("FAIL single_release got %b want 001011010", {GNT_A, GNT_B, E, S, DVALID, DOUT});
        end
        @(negedge CLK);
        total++;
        if ({DVALID, DOUT} !== 5'b0_1010) begin
            bad++; $display("FAIL single_idle got dv=%b dout=%h want 0 a", DVALID, DOUT);
        end
    endtask

    task automatic test_rotation();
        logic own, prev;
        do_reset();
        REQ_A = 1'b1; REQ_B = 1'b1;
        prev = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            own = (k > 4);
            total++;
            if ({GNT_A, GNT_B, E, S} !== {~own, own, 1'b0, own}) begin
                bad++; $display("FAIL rot_gnt k=%0d got %b want %b", k, {GNT_A, GNT_B, E, S}, {~own, own, 1'b0, own});
            end
            if (k >= 2) begin
                total++;
                if ({DVALID, DSRC, DOUT} !== {1'b1, prev, (prev ? 4'h5 : 4'hA)}) begin
                    bad++; $display("FAIL rot_data k=%0d got dv=%b src=%b dout=%h want src=%b", k, DVALID, DSRC, DOUT, prev);
                end
            end
            prev = own;
        end
        REQ_A = 1'b0; REQ_B = 1'b0;
        @(negedge CLK);
        total++;
        if ({GNT_A, GNT_B, E, S, DVALID, DSRC, DOUT} !== 10'b0011_11_0101) begin
            bad++; $display("FAIL rot_idle got %b want 0011110101", {GNT_A, GNT_B, E, S, DVALID, DSRC, DOUT});
        end
    endtask

    task automatic test_handoff();
        do_reset();
        REQ_A = 1'b1;
        repeat (2) @(negedge CLK);
        total++;
        if ({GNT_A, GNT_B} !== 2'b10) begin
            bad++; $display("FAIL hand_pre got %b want 10", {GNT_A, GNT_B});
        end
        REQ_A = 1'b0; REQ_B = 1'b1;
        @(negedge CLK);
        total++;
        if ({GNT_A, GNT_B, E, S, DVALID, DSRC, DOUT} !== 10'b0101_10_1010) begin
            bad++; $display("FAIL hand_switch got %b want 0101101010", {GNT_A, GNT_B, E, S, DVALID, DSRC, DOUT});
        end
        REQ_A = 1'b1;
        for (int k = 4; k <= 7; k++) begin
            @(negedge CLK);
            total++;
            if ({GNT_A, GNT_B, E} !== ((k == 7) ? 3'b100 : 3'b010)) begin
                bad++; $display("FAIL hand_hold k=%0d got %b want %b", k, {GNT_A, GNT_B, E}, (k == 7) ? 3'b100 : 3'b010);
            end
        end
    endtask

    task automatic test_hold1();
        logic own, prev;
        do_reset();
        r1_a = 1'b1; r1_b = 1'b1;
        prev = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            own = (k % 2 == 0);
            total++;
            if ({g1_a, g1_b, e1, s1} !== {~own, own, 1'b0, own}) begin
                bad++; $display("FAIL h1_gnt k=%0d got %b want %b", k, {g1_a, g1_b, e1, s1}, {~own, own, 1'b0, own});
            end
            if (k >= 2) begin
                total++;
                if ({dv1, ds1, do1} !== {1'b1, prev, (prev ? 4'h5 : 4'hA)}) begin
                    bad++; $display("FAIL h1_data k=%0d got dv=%b src=%b dout=%h want src=%b", k, dv1, ds1, do1, prev);
                end
            end
            prev = own;
        end
        r1_a = 1'b0; r1_b = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        REQ_B = 1'b1;
        repeat (2) @(negedge CLK);
        total++;
        if ({GNT_B, DVALID, DOUT} !== 6'b11_0101) begin
            bad++; $display("FAIL async_pre got %b want 110101", {GNT_B, DVALID, DOUT});
        end
        #2 RST = 1'b1;
        #1;
        total++;
        if ({GNT_A, GNT_B, E, S, DVALID, DOUT} !== 9'b0010_0_0000) begin
            bad++; $display("FAIL async_clear got %b want 001000000", {GNT_A, GNT_B, E, S, DVALID, DOUT});
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if ({GNT_A, GNT_B, E, S} !== 4'b0101) begin
            bad++; $display("FAIL async_regrant got %b want 0101", {GNT_A, GNT_B, E, S});
        end
        REQ_B = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_handoff();
        test_hold1();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux157_share_arbiter.md
Name: mux157_share_arbiter

Overview:
- Sequencer/arbiter that shares one quad 2-to-1 multiplexer (Vr74x157: active-low enable E, select S, A/B 4-bit inputs, Y 4-bit output) between two requesters, A and B.
- Grants the mux round-robin with a bounded hold time.
- Drives the mux E and S controls, registers the mux output Y, and tags each captured word with its source.
- Sits between the two requesting datapaths and the Vr74x157 instance.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester keeps the grant while the other is requesting; legal range >= 1.
- CW, $clog2(MAX_HOLD)+1: hold-counter width; derived, do not override.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- REQ_A  input  1  requester A wants the mux.
- REQ_B  input  1  requester B wants the mux.
- GNT_A  output  1  A owns the mux this cycle; registered.
- GNT_B  output  1  B owns the mux this cycle; registered.
- E  output  1  to mux E; active low; 0 only while a grant is active; registered.
- S  output  1  to mux S; 0 selects A inputs, 1 selects B inputs; registered.
- Y  input  4  mux output Y3..Y0 (Y[0]=Y0).
- DOUT  output  4  captured mux output.
- DVALID  output  1  DOUT updated this cycle.
- DSRC  output  1  source of DOUT; 0 = A, 1 = B.

Behaviour:
- One clock (CLK); RST is asynchronous and active-high. Asserting RST takes effect immediately, with no clock edge.
- Reset values:
  - state=IDLE, GNT_A=0, GNT_B=0, E=1, S=0.
  - DOUT=4'h0, DVALID=0, DSRC=0, hold_cnt=0.
  - last=1, so A wins the first tie.
- States: IDLE, OWN_A, OWN_B. All outputs are registered and decoded from the next state.
  - OWN_A: GNT_A=1, E=0, S=0.
  - OWN_B: GNT_B=1, E=0, S=1.
  - IDLE: both grants 0, E=1, S keeps its last value.
- IDLE transitions:
  - Only REQ_A -> OWN_A.
  - Only REQ_B -> OWN_B.
  - Both requesting -> the requester not equal to last.
  - Neither -> stay in IDLE.
- OWN_x, where y is the other requester:
  - REQ_x=0 and REQ_y=1 -> OWN_y directly, with no idle bubble.
  - REQ_x=0 and REQ_y=0 -> IDLE.
  - REQ_x=1, REQ_y=1, hold_cnt==MAX_HOLD-1 -> OWN_y (forced rotation).
  - Otherwise stay in OWN_x.
- Hold counter (hold_cnt):
  - Loads 0 on every grant entry, including a direct A<->B switch.
  - Increments each cycle the grant is held.
  - Saturates at MAX_HOLD-1; with the other side idle, the owner keeps the grant indefinitely.
  - MAX_HOLD=1 with both requesting: the grant alternates every cycle.
- last updates to the new owner on every grant entry.
- Grant latency: a request seen at edge n gives a grant visible after edge n. A requester must hold REQ until it sees its GNT.
- Direct switch: one GNT falls and the other rises on the same edge, S toggles, and E stays 0. Both grants are never 1 in the same cycle.
- Capture:
  - Each edge where E==0 (a grant active in the ending cycle): DOUT<=Y, DSRC<=S, DVALID<=1.
  - Otherwise DVALID<=0 and DOUT/DSRC hold.
  - Result: data selected in cycle t appears on DOUT in cycle t+1, with a latency of one cycle.
- REQ_x dropping mid-grant is not an error. The grant ends on the next edge, and the final cycle's Y is still captured.
- RST during a grant: grants, E, DVALID and the counter clear immediately. The word in flight is discarded; DOUT returns to 0.
- The bench models the mux behaviourally: E=1 forces Y=4'h0; otherwise Y=S?B:A.

Test Plan:
- Reset check: RST=1 with REQ_A=REQ_B=1 -> GNT_A=GNT_B=0, E=1, S=0, DOUT=0, DVALID=0. Release RST -> GNT_A=1 after the next edge; first tie goes to A.
- Single requester: A=4'hA, B=4'h5, REQ_A=1 for 6 cycles -> GNT_A held 6 cycles and E=0. DOUT=4'hA with DVALID=1, DSRC=0 from one cycle after grant until one cycle after release. Then IDLE, E=1.
- Forced rotation: MAX_HOLD=4, REQ_A=REQ_B=1 continuously -> grant pattern A,A,A,A,B,B,B,B,A...; S toggles every 4 cycles and E stays 0. DOUT sequence is 4'hA x4, then 4'h5 x4; DSRC tracks S with a one-cycle lag.
- Early release handoff: REQ_A=1, then REQ_B rises and REQ_A drops after 2 granted cycles -> GNT_B rises on the same edge GNT_A falls, with no idle cycle. The hold counter restarts at 0.
- MAX_HOLD=1 with both requesting -> grant alternates A,B,A,B each cycle; DOUT alternates 4'hA, 4'h5.
- Async reset mid-burst: assert RST between edges while GNT_B=1 -> GNT_B, DVALID go 0 and E goes 1 immediately, without waiting for CLK. After release with only REQ_B=1 -> GNT_B returns after one edge.
